// File: rtl/regfile_dbg_port.sv
// Debug save/restore engine: sweeps r1..r31 of the integer register file, either streaming
// them out through read port 1 (dump) or writing an input stream through the write port (load).
module regfile_dbg_port #(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    output logic         busy,
    output logic         done,
    output logic [4:0]   rR1,
    input  logic [n-1:0] dR1,
    output logic         regw,
    output logic [4:0]   waddr,
    output logic [n-1:0] wdata,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [n-1:0] dout_data,
    output logic [4:0]   dout_idx,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [n-1:0] din_data,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DUMP  = 3'd1,
        S_DRAIN = 3'd2,
        S_LOAD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_idx;
    logic           r_dout_valid;
    logic [n-1:0]   r_dout_data;
    logic [4:0]     r_dout_idx;
    logic           w_slot_free;
    logic           w_dump_load;
    logic           w_din_fire;
    logic           w_idx_last;

    // Both streams: a word moves on the rising edge where valid && ready are both high;
    // the producer keeps valid, data and index stable until that edge.
    always_comb begin
        w_slot_free = !r_dout_valid || dout_ready;
        w_idx_last  = (r_idx == 5'd31);
        w_dump_load = (r_state == S_DUMP) && w_slot_free;
        w_din_fire  = (r_state == S_LOAD) && !reset && din_valid;
        w_next      = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = mode ? S_LOAD : S_DUMP;
            S_DUMP:  if (w_dump_load && w_idx_last) w_next = S_DRAIN;
            S_DRAIN: if (dout_ready) w_next = S_DONE;
            S_LOAD:  if (w_din_fire && w_idx_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= 5'd1;
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
            r_dout_idx   <= 5'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_idx <= 5'd1;
            end else if (w_dump_load || w_din_fire) begin
                r_idx <= r_idx + 5'd1;
            end
            // The output register refills in the same cycle its word is taken, so no bubble.
            if (w_dump_load) begin
                r_dout_valid <= 1'b1;
                r_dout_data  <= dR1;
                r_dout_idx   <= r_idx;
            end else if (r_state == S_DRAIN && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy       = (r_state == S_DUMP) || (r_state == S_DRAIN) || (r_state == S_LOAD);
        done       = (r_state == S_DONE);
        rR1        = (r_state == S_DUMP) ? r_idx : 5'd0;
        din_ready  = (r_state == S_LOAD) && !reset;
        regw       = w_din_fire;
        waddr      = w_din_fire ? r_idx : 5'd0;
        wdata      = w_din_fire ? din_data : '0;
        dout_valid = r_dout_valid;
        dout_data  = r_dout_data;
        dout_idx   = r_dout_idx;
        dbg_state  = r_state;
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Bench for regfile_dbg_port: a behavioural register file plus a per-register model;
// randomized dump/load sweeps are scored against it.
module tb_regfile_dbg_port;
    localparam int N = 32;
    localparam int W = 37;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         dout_ready = 1'b0;
    logic         din_valid = 1'b0;
    logic [N-1:0] din_data = '0;
    logic         busy, done, regw, dout_valid, din_ready;
    logic [4:0]   rR1, waddr, dout_idx;
    logic [N-1:0] dR1, wdata, dout_data;
    logic [2:0]   dbg_state;

    regfile_dbg_port #(.n(N)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .busy(busy), .done(done), .rR1(rR1), .dR1(dR1),
        .regw(regw), .waddr(waddr), .wdata(wdata),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_idx(dout_idx),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dbg_state(dbg_state)
    );

    // clock / environment register file
    always #5 clock = ~clock;

    logic         preload = 1'b1;
    logic [N-1:0] rf [32];
    assign dR1 = rf[rR1];
    always @(posedge clock) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) rf[k] <= (k == 0) ? '0 : 32'h100 + N'(k);
        end else if (regw) begin
            rf[waddr] <= wdata;
        end
    end

    // drive shadows, applied just after each rising edge
    logic         d_rst = 1'b1, d_start = 1'b0, d_mode = 1'b0, d_rdy = 1'b0, d_dv = 1'b0;
    logic [N-1:0] d_dd = '0;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    logic [N-1:0] cap_q[$];
    logic [N-1:0] ld_q[$];
    logic [N-1:0] cap1[$];
    logic [N-1:0] mdl [32];
    int n_acc, first_acc, last_acc, wr_cnt, ld_cnt, last_hs, done_cnt, done_cyc;
    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_data;
    logic [4:0]   prev_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe();
        logic [W-1:0] e;
        logic hs;
        if (prev_stall) begin
            check("stall_valid", 64'(dout_valid), 64'd1);
            check("stall_data", 64'(dout_data), 64'(prev_data));
            check("stall_idx", 64'(dout_idx), 64'(prev_idx));
        end
        prev_stall = (dout_valid === 1'b1) && (dout_ready === 1'b0) && !reset;
        prev_data  = dout_data;
        prev_idx   = dout_idx;
        if (dout_valid === 1'b1 && dout_ready && !reset) begin
            if (exp_q.size() == 0) begin
                check("dout_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("dout_idx", 64'(dout_idx), 64'(e[36:32]));
                check("dout_data", 64'(dout_data), 64'(e[31:0]));
            end
            cap_q.push_back(dout_data);
            n_acc++;
            if (n_acc == 1) first_acc = cyc;
            last_acc = cyc;
        end
        hs = (din_valid === 1'b1) && (din_ready === 1'b1) && !reset;
        if (hs || regw === 1'b1) begin
            check("regw_hs", 64'(regw), 64'(hs));
            if (hs) begin
                check("waddr", 64'(waddr), 64'(ld_cnt + 1));
                check("wdata", 64'(wdata), 64'(din_data));
                if (ld_cnt < 31) begin
                    ld_cnt++;
                    mdl[ld_cnt] = din_data;
                end
                last_hs = cyc;
            end
        end
        if (regw === 1'b1) wr_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        reset = d_rst; start = d_start; mode = d_mode;
        dout_ready = d_rdy; din_valid = d_dv; din_data = d_dd;
        @(negedge clock);
        cyc++;
        observe();
    endtask

    task automatic check_idle(input bit full);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_dout_valid", 64'(dout_valid), 64'd0);
        check("idle_din_ready", 64'(din_ready), 64'd0);
        check("idle_regw", 64'(regw), 64'd0);
        check("idle_rR1", 64'(rR1), 64'd0);
        check("idle_waddr", 64'(waddr), 64'd0);
        check("idle_wdata", 64'(wdata), 64'd0);
        check("idle_state", 64'(dbg_state), 64'd0);
        if (full) begin
            check("idle_dout_data", 64'(dout_data), 64'd0);
            check("idle_dout_idx", 64'(dout_idx), 64'd0);
        end
    endtask

    task automatic check_rf();
        for (int k = 0; k < 32; k++) check($sformatf("rf_r%0d", k), 64'(rf[k]), 64'(mdl[k]));
    endtask

    // pat 0: ready held high, 1: ready 1,0,0 repeating, 2: random ready
    task automatic run_dump(input int pat, input bit poke);
        int r;
        int t;
        int first_valid;
        exp_q.delete();
        cap_q.delete();
        for (int k = 1; k < 32; k++) exp_q.push_back({5'(k), mdl[k]});
        n_acc = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid = -1;
        d_dv = 1'b0; d_start = 1'b1; d_mode = 1'b0; d_rdy = 1'b1;
        step();
        t = cyc;
        r = 0;
        check("dump_busy_t0", 64'(busy), 64'd0);
        while (done_cyc < 0 && r < 200) begin
            r++;
            d_start = 1'b0;
            d_mode  = 1'($urandom_range(0, 1));
            if (poke && (r == 10 || r == 33)) begin
                d_start = 1'b1;
                d_mode  = 1'b1;
            end
            case (pat)
                0:       d_rdy = 1'b1;
                1:       d_rdy = (r % 3 == 1);
                default: d_rdy = 1'($urandom_range(0, 1));
            endcase
            step();
            if (dout_valid === 1'b1 && first_valid < 0) first_valid = r;
            if (r == 1) check("dump_busy_rise", 64'(busy), 64'd1);
        end
        if (done_cyc < 0) check("dump_timeout", 64'd0, 64'd1);
        check("dump_done_busy", 64'(busy), 64'd0);
        d_start = 1'b0; d_rdy = 1'b1;
        step();
        check("dump_post_busy", 64'(busy), 64'd0);
        check("dump_post_done", 64'(done), 64'd0);
        check("dump_post_state", 64'(dbg_state), 64'd0);
        check("dump_words", 64'(n_acc), 64'd31);
        check("dump_left", 64'(exp_q.size()), 64'd0);
        check("dump_regw", 64'(wr_cnt), 64'd0);
        check("dump_done_cnt", 64'(done_cnt), 64'd1);
        check("dump_done_after_last", 64'(done_cyc - last_acc), 64'd1);
        if (pat == 0) begin
            check("dump_first_valid", 64'(first_valid), 64'd2);
            check("dump_first_acc", 64'(first_acc - t), 64'd2);
            check("dump_last_acc", 64'(last_acc - t), 64'd32);
            check("dump_done_at", 64'(done_cyc - t), 64'd33);
        end
    endtask

    // pat 0: valid held high, 1: valid low every third cycle, 2: random valid
    task automatic run_load(input int pat, input int abort_at);
        int r;
        int t;
        ld_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
        d_dv = 1'b0; d_start = 1'b1; d_mode = 1'b1;
        step();
        t = cyc;
        r = 0;
        while (done_cyc < 0 && r < 200 && !(abort_at > 0 && ld_cnt >= abort_at)) begin
            r++;
            d_start = 1'b0;
            d_mode  = 1'($urandom_range(0, 1));
            case (pat)
                0:       d_dv = 1'b1;
                1:       d_dv = (r % 3 != 0);
                default: d_dv = 1'($urandom_range(0, 1));
            endcase
            d_dd = (d_dv && ld_cnt < 31) ? ld_q[ld_cnt] : N'($urandom);
            step();
        end
        if (abort_at > 0) begin
            d_rst = 1'b1; d_dv = 1'b1; d_dd = ld_q[abort_at];
            step();
            check("rst_regw", 64'(regw), 64'd0);
            check("rst_din_ready", 64'(din_ready), 64'd0);
            d_rst = 1'b0;
            step();
            check_idle(1'b0);
            check("abort_writes", 64'(wr_cnt), 64'(abort_at));
            d_dv = 1'b0;
        end else begin
            if (done_cyc < 0) check("load_timeout", 64'd0, 64'd1);
            d_dv = 1'b0;
            step();
            check("load_post_busy", 64'(busy), 64'd0);
            check("load_words", 64'(ld_cnt), 64'd31);
            check("load_writes", 64'(wr_cnt), 64'd31);
            check("load_done_cnt", 64'(done_cnt), 64'd1);
            check("load_done_after_last", 64'(done_cyc - last_hs), 64'd1);
            if (pat == 0) check("load_done_at", 64'(done_cyc - t), 64'd32);
        end
    endtask

    initial begin
        mdl[0] = '0;
        for (int k = 1; k < 32; k++) mdl[k] = 32'h100 + N'(k);
        d_rst = 1'b1;
        step();
        step();
        preload = 1'b0;
        d_rst = 1'b0;
        step();
        check_idle(1'b1);

        run_dump(0, 1'b0);
        run_dump(1, 1'b0);
        run_dump(0, 1'b1);

        ld_q.delete();
        for (int k = 1; k < 32; k++) ld_q.push_back(32'hA000_0000 + N'(k));
        run_load(1, 0);
        check_rf();
        check("rf_r5_abs", 64'(rf[5]), 64'h0000_0000_A000_0005);

        ld_q.delete();
        for (int k = 1; k < 32; k++) ld_q.push_back(32'hB000_0000 + N'(k));
        run_load(0, 10);
        check_rf();
        check("rf_r11_abs", 64'(rf[11]), 64'h0000_0000_A000_000B);
        run_dump(0, 1'b0);

        run_dump(2, 1'b0);
        cap1 = cap_q;
        ld_q.delete();
        for (int k = 1; k < 32; k++) ld_q.push_back(N'($urandom));
        run_load(2, 0);
        check_rf();
        ld_q = cap1;
        run_load(2, 0);
        check_rf();
        run_dump(2, 1'b0);
        check("rt_len", 64'(cap_q.size()), 64'(cap1.size()));
        for (int k = 0; k < cap1.size() && k < cap_q.size(); k++)
            check($sformatf("rt_w%0d", k + 1), 64'(cap_q[k]), 64'(cap1[k]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
